// File: rtl/ica_moment_accumulator.sv
// FastICA one-unit moment accumulator: streams one frame of whitened samples against a
// latched weight vector and emits the un-normalised update E{z*g(y)} - E{g'(y)}*W.
module ica_moment_accumulator #(
   parameter int unsigned N_LOG2 = 14,
   parameter int unsigned Z_FRAC = 12,
   parameter int unsigned W_FRAC = 14,
   parameter int unsigned ACC_W  = 64
) (
   input  logic                CLK_ica,
   input  logic                RST_ica,
   input  logic                GO_ica,
   input  logic signed [15:0]  W1,
   input  logic signed [15:0]  W2,
   input  logic signed [15:0]  W3,
   input  logic signed [15:0]  W4,
   input  logic                Z_valid,
   input  logic signed [25:0]  Z1,
   input  logic signed [25:0]  Z2,
   input  logic signed [25:0]  Z3,
   input  logic signed [25:0]  Z4,
   output logic                Z_ready,
   output logic                ica_busy,
   output logic                done,
   output logic [N_LOG2:0]     sample_cnt,
   output logic signed [25:0]  W_new1,
   output logic signed [25:0]  W_new2,
   output logic signed [25:0]  W_new3,
   output logic signed [25:0]  W_new4
);

   localparam int unsigned W_W   = 16;
   localparam int unsigned Z_W   = 26;
   localparam int unsigned P_W   = W_W + Z_W;
   localparam int unsigned PS_W  = P_W + 2;
   localparam int unsigned MUL_W = 2 * Z_W;
   localparam int unsigned D_W   = Z_W + 2;
   localparam int unsigned SAT_W = ACC_W + W_W;
   localparam int unsigned CNT_W = N_LOG2 + 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(1) << N_LOG2;
   localparam logic signed [SAT_W-1:0] SAT_HI = SAT_W'(2 ** (Z_W - 1) - 1);
   localparam logic signed [SAT_W-1:0] SAT_LO = SAT_W'(-(2 ** (Z_W - 1)));

   typedef enum logic [2:0] {IDLE, ACCUM, DRAIN, FINAL, DONE} state_t;

   state_t                  state, state_nx;
   logic [CNT_W-1:0]        cnt_nx;
   logic                    hs;
   logic                    load_w;

   logic signed [W_W-1:0]   w_in   [4];
   logic signed [Z_W-1:0]   z_in   [4];
   logic signed [W_W-1:0]   wl     [4];
   logic signed [P_W-1:0]   p      [4];
   logic signed [Z_W-1:0]   z_s1   [4];
   logic signed [Z_W-1:0]   z_s2   [4];
   logic signed [Z_W-1:0]   z_s3   [4];
   logic signed [Z_W-1:0]   z_s4   [4];
   logic signed [Z_W-1:0]   y_s2, y_s3, y2_s3, y2_s4, y3_s4;
   logic [4:0]              vld;
   logic signed [ACC_W-1:0] acc    [4];
   logic signed [ACC_W-1:0] acc_d;
   logic signed [Z_W-1:0]   wn     [4];

   logic signed [PS_W-1:0]  psum;
   logic signed [MUL_W-1:0] yy, y2y;
   logic signed [MUL_W-1:0] zy     [4];
   logic signed [D_W-1:0]   y2x3;
   logic signed [ACC_W-1:0] md;
   logic signed [ACC_W-1:0] m_c    [4];
   logic signed [SAT_W-1:0] corr_c [4];
   logic signed [Z_W-1:0]   wn_c   [4];

   assign w_in = '{W1, W2, W3, W4};
   assign z_in = '{Z1, Z2, Z3, Z4};
   assign W_new1 = wn[0];
   assign W_new2 = wn[1];
   assign W_new3 = wn[2];
   assign W_new4 = wn[3];

   function automatic logic signed [Z_W-1:0] sat26(input logic signed [SAT_W-1:0] x);
      return Z_W'((x > SAT_HI) ? SAT_HI : ((x < SAT_LO) ? SAT_LO : x));
   endfunction

   // Frame sequencing: accept GO in IDLE only, count handshakes, drain, finalise.
   always_comb begin
      state_nx = state;
      cnt_nx   = sample_cnt;
      hs       = 1'b0;
      load_w   = 1'b0;
      case (state)
         IDLE: begin
            if (GO_ica) begin
               load_w   = 1'b1;
               cnt_nx   = '0;
               state_nx = ACCUM;
            end
         end
         ACCUM: begin
            hs     = Z_valid & Z_ready;
            cnt_nx = sample_cnt + CNT_W'(hs);
            if (cnt_nx == CNT_MAX) state_nx = DRAIN;
         end
         DRAIN: begin
            if (vld == '0) state_nx = FINAL;
         end
         FINAL:   state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge CLK_ica or posedge RST_ica) begin
      if (RST_ica) begin
         state      <= IDLE;
         sample_cnt <= '0;
         Z_ready    <= 1'b0;
         ica_busy   <= 1'b0;
         done       <= 1'b0;
      end else begin
         state      <= state_nx;
         sample_cnt <= cnt_nx;
         Z_ready    <= (state_nx == ACCUM) && (cnt_nx < CNT_MAX);
         ica_busy   <= (state_nx != IDLE);
         done       <= (state_nx == DONE);
      end
   end

   // Datapath products; widths are chosen so no intermediate can overflow.
   always_comb begin
      psum = PS_W'(p[0]) + PS_W'(p[1]) + PS_W'(p[2]) + PS_W'(p[3]);
      yy   = MUL_W'(y_s2) * MUL_W'(y_s2);
      y2y  = MUL_W'(y2_s3) * MUL_W'(y_s3);
      y2x3 = (D_W'(y2_s4) <<< 1) + D_W'(y2_s4);
      md   = acc_d >>> N_LOG2;
      for (int i = 0; i < 4; i++) begin
         zy[i]     = MUL_W'(z_s4[i]) * MUL_W'(y3_s4);
         m_c[i]    = acc[i] >>> N_LOG2;
         corr_c[i] = (SAT_W'(md) * SAT_W'(wl[i])) >>> W_FRAC;
         wn_c[i]   = sat26(SAT_W'(m_c[i]) - corr_c[i]);
      end
   end

   // Five-stage moment pipeline; vld[4] marks a sample whose sums have landed.
   always_ff @(posedge CLK_ica or posedge RST_ica) begin
      if (RST_ica) begin
         vld   <= '0;
         y_s2  <= '0;
         y_s3  <= '0;
         y2_s3 <= '0;
         y2_s4 <= '0;
         y3_s4 <= '0;
         acc_d <= '0;
         for (int i = 0; i < 4; i++) begin
            wl[i]   <= '0;
            p[i]    <= '0;
            z_s1[i] <= '0;
            z_s2[i] <= '0;
            z_s3[i] <= '0;
            z_s4[i] <= '0;
            acc[i]  <= '0;
            wn[i]   <= '0;
         end
      end else begin
         vld   <= {vld[3:0], hs};
         y_s2  <= sat26(SAT_W'(psum >>> W_FRAC));
         y_s3  <= y_s2;
         y2_s3 <= sat26(SAT_W'(yy >>> Z_FRAC));
         y2_s4 <= y2_s3;
         y3_s4 <= sat26(SAT_W'(y2y >>> Z_FRAC));
         if (load_w)      acc_d <= '0;
         else if (vld[3]) acc_d <= acc_d + ACC_W'(y2x3);
         for (int i = 0; i < 4; i++) begin
            if (load_w) wl[i] <= w_in[i];
            p[i]    <= P_W'(wl[i]) * P_W'(z_in[i]);
            z_s1[i] <= z_in[i];
            z_s2[i] <= z_s1[i];
            z_s3[i] <= z_s2[i];
            z_s4[i] <= z_s3[i];
            if (load_w)      acc[i] <= '0;
            else if (vld[3]) acc[i] <= acc[i] + ACC_W'(zy[i] >>> Z_FRAC);
            if (state == FINAL) wn[i] <= wn_c[i];
         end
      end
   end

endmodule

// File: tb/tb_ica_moment_accumulator.sv
// Scoreboard bench for ica_moment_accumulator with a 4-sample frame: expected W_new values
// come from a behavioural model and are queued per frame, then popped on the done pulse.
module tb_ica_moment_accumulator;

   localparam int unsigned N_LOG2 = 2;
   localparam int FRAME = 1 << N_LOG2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic go = 1'b0;
   logic signed [15:0] w1 = '0, w2 = '0, w3 = '0, w4 = '0;
   logic zv = 1'b0;
   logic signed [25:0] z1 = '0, z2 = '0, z3 = '0, z4 = '0;
   logic Z_ready, ica_busy, done;
   logic [N_LOG2:0] sample_cnt;
   logic signed [25:0] W_new1, W_new2, W_new3, W_new4;
   logic signed [25:0] wn [4];

   int n_vec = 0;
   int n_bad = 0;
   int cyc = 0;
   int last_hs = 0;
   longint cur_w [4];
   longint zf [$];
   longint exp_q [$];

   ica_moment_accumulator #(.N_LOG2(N_LOG2)) dut (
      .CLK_ica(clk), .RST_ica(rst), .GO_ica(go),
      .W1(w1), .W2(w2), .W3(w3), .W4(w4),
      .Z_valid(zv), .Z1(z1), .Z2(z2), .Z3(z3), .Z4(z4),
      .Z_ready(Z_ready), .ica_busy(ica_busy), .done(done), .sample_cnt(sample_cnt),
      .W_new1(W_new1), .W_new2(W_new2), .W_new3(W_new3), .W_new4(W_new4)
   );

   assign wn[0] = W_new1;
   assign wn[1] = W_new2;
   assign wn[2] = W_new3;
   assign wn[3] = W_new4;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic signed [63:0] got,
                        input logic signed [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic longint sat26(input longint x);
      if (x > 33554431) return 33554431;
      if (x < -33554432) return -33554432;
      return x;
   endfunction

   task automatic push_expected();
      longint acc [4];
      longint accd, s, y, y2, y3, md;
      acc  = '{default: 0};
      accd = 0;
      for (int k = 0; k < zf.size() / 4; k++) begin
         s = 0;
         for (int i = 0; i < 4; i++) s += cur_w[i] * zf[4*k+i];
         y  = sat26(s >>> 14);
         y2 = sat26((y * y) >>> 12);
         y3 = sat26((y2 * y) >>> 12);
         for (int i = 0; i < 4; i++) acc[i] += (zf[4*k+i] * y3) >>> 12;
         accd += 3 * y2;
      end
      md = accd >>> N_LOG2;
      for (int i = 0; i < 4; i++)
         exp_q.push_back(sat26((acc[i] >>> N_LOG2) - ((md * cur_w[i]) >>> 14)));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_frame(input longint a, input longint b, input longint c, input longint d);
      cur_w = '{a, b, c, d};
      zf.delete();
      w1 = 16'(a); w2 = 16'(b); w3 = 16'(c); w4 = 16'(d);
      go = 1'b1;
      tick();
      go = 1'b0;
      check("busy_after_go", ica_busy, 1);
      check("ready_after_go", Z_ready, 1);
      check("cnt_cleared", sample_cnt, 0);
   endtask

   task automatic send(input longint a, input longint b, input longint c, input longint d,
                       input int gap);
      int n;
      for (int g = 0; g < gap; g++) begin
         zv = 1'b0;
         tick();
      end
      z1 = 26'(a); z2 = 26'(b); z3 = 26'(c); z4 = 26'(d);
      zv = 1'b1;
      n = 0;
      while (!Z_ready && n < 20) begin
         tick();
         n++;
      end
      if (!Z_ready) check("ready_wait", Z_ready, 1);
      tick();
      zv = 1'b0;
      last_hs = cyc;
      zf.push_back(a); zf.push_back(b); zf.push_back(c); zf.push_back(d);
   endtask

   task automatic wait_done(input string tag, input bit go_on_done);
      int n;
      longint e;
      push_expected();
      n = 0;
      while (!done && n < 40) begin
         tick();
         n++;
      end
      check({tag, "_done"}, done, 1);
      for (int i = 0; i < 4; i++) begin
         e = exp_q.pop_front();
         if (done) check($sformatf("%s_wnew%0d", tag, i + 1), wn[i], e);
      end
      if (done) begin
         check({tag, "_latency"}, cyc - last_hs, 7);
         check({tag, "_cnt"}, sample_cnt, FRAME);
         check({tag, "_busy_in_done"}, ica_busy, 1);
         if (go_on_done) go = 1'b1;
         tick();
         go = 1'b0;
         check({tag, "_done_pulse"}, done, 0);
         check({tag, "_busy_fall"}, ica_busy, 0);
      end
   endtask

   task automatic frame_unit(input string tag);
      start_frame(16384, 0, 0, 0);
      for (int k = 0; k < FRAME; k++) send(4096, 0, 0, 0, 0);
      wait_done(tag, 1'b0);
      check({tag, "_lit"}, W_new1, -8192);
   endtask

   initial begin
      int seen;
      longint r [4];
      // reset values
      repeat (2) tick();
      check("rst_wnew1", W_new1, 0);
      check("rst_busy", ica_busy, 0);
      check("rst_ready", Z_ready, 0);
      check("rst_done", done, 0);
      check("rst_cnt", sample_cnt, 0);
      rst = 1'b0;
      tick();

      frame_unit("unit");

      start_frame(16384, 0, 0, 0);
      for (int k = 0; k < FRAME; k++) send((k % 2 == 0) ? 4096 : -4096, 0, 0, 0, 0);
      wait_done("alt", 1'b0);
      check("alt_lit", W_new1, -8192);

      start_frame(-16384, 0, 0, 0);
      for (int k = 0; k < FRAME; k++) send((k % 2 == 0) ? -4096 : 4096, 0, 0, 0, 0);
      wait_done("negw", 1'b0);

      start_frame(16384, 0, 0, 0);
      for (int k = 0; k < FRAME; k++) send(33554431, 0, 0, 0, 0);
      wait_done("satpos", 1'b0);
      check("satpos_lit", W_new1, 33554431);

      start_frame(16384, 0, 0, 0);
      for (int k = 0; k < FRAME; k++) send(-33554432, 0, 0, 0, 0);
      wait_done("satneg", 1'b0);

      for (int f = 0; f < 3; f++) begin
         for (int i = 0; i < 4; i++) r[i] = longint'($urandom_range(0, 32767)) - 16384;
         start_frame(r[0], r[1], r[2], r[3]);
         for (int k = 0; k < FRAME; k++) begin
            for (int i = 0; i < 4; i++) r[i] = longint'($urandom_range(0, 2097152)) - 1048576;
            send(r[0], r[1], r[2], r[3], int'($urandom_range(0, 2)));
         end
         wait_done($sformatf("rand%0d", f), 1'b0);
      end

      // Z_valid in IDLE is ignored, bubbles do not count, Z_valid in DRAIN is ignored
      zv = 1'b1; z1 = 26'(12345);
      repeat (2) tick();
      check("idle_zv_cnt", sample_cnt, FRAME);
      check("idle_zv_ready", Z_ready, 0);
      zv = 1'b0;
      start_frame(12000, -3000, 5000, 800);
      send(100000, -50000, 20000, 7000, 0);
      check("bub_cnt1", sample_cnt, 1);
      send(-80000, 30000, 90000, -1000, 2);
      check("bub_cnt2", sample_cnt, 2);
      send(60000, 60000, -60000, 400000, 1);
      check("bub_cnt3", sample_cnt, 3);
      send(-200000, 10, 70000, 50000, 0);
      check("bub_cnt4", sample_cnt, 4);
      check("bub_ready_low", Z_ready, 0);
      zv = 1'b1; z1 = 26'(9999999);
      repeat (2) tick();
      zv = 1'b0;
      check("drain_zv_cnt", sample_cnt, FRAME);
      wait_done("bubble", 1'b0);

      // async reset mid-frame
      start_frame(16384, 0, 0, 0);
      send(4096, 0, 0, 0, 0);
      send(4096, 0, 0, 0, 0);
      rst = 1'b1;
      #1;
      check("mid_rst_wnew1", W_new1, 0);
      check("mid_rst_busy", ica_busy, 0);
      check("mid_rst_ready", Z_ready, 0);
      check("mid_rst_cnt", sample_cnt, 0);
      check("mid_rst_done", done, 0);
      tick();
      rst = 1'b0;
      tick();
      frame_unit("after_rst");

      // GO while busy and on the done cycle, W changed mid-frame
      start_frame(16384, 0, 0, 0);
      send(4096, 0, 0, 0, 0);
      send(4096, 0, 0, 0, 0);
      w1 = 16'(5000); w2 = 16'(-7000); w3 = 16'(300); w4 = 16'(16000);
      go = 1'b1;
      tick();
      go = 1'b0;
      check("go_busy_cnt", sample_cnt, 2);
      send(4096, 0, 0, 0, 0);
      send(4096, 0, 0, 0, 0);
      wait_done("go_busy", 1'b1);
      check("go_busy_lit", W_new1, -8192);
      seen = 0;
      for (int k = 0; k < 12; k++) begin
         if (done || ica_busy) seen++;
         tick();
      end
      check("no_second_frame", seen, 0);
      check("wnew_held", W_new1, -8192);
      check("queue_empty", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
